pipe_skid_register: RTL and testbench

- Two-entry valid/ready pipeline register (main + skid) placed between processor stages, e.g. decode -> execute.
- Feeds the downstream stage's REGISTER_MODULE-style data latch.
- Breaks the combinational ready path: IN_READY depends only on internal state, never on OUT_READY.
- Supports stage flush for branch redirect.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_register.sv | 135 +++++++++++++
 tb/tb_pipe_skid_register.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry valid/ready pipeline skid register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Fill bit replicated across the payload width to form the reset pattern.
  localparam logic PIPE_RESET_DATA = 1'b1;

  function automatic logic pipe_in_ready(input pipe_state_t state);
    return (state != TWO);
  endfunction

  function automatic logic pipe_out_valid(input pipe_state_t state);
    return (state != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_skid_register.sv
// Two-entry (main + skid) valid/ready pipeline register; IN_READY comes from state only.
// Optional stall counter on STALL_COUNT when PIPE_STALL_STATS_EN is defined.
module pipe_skid_register
  import pipe_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int STAT_SIZE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DATA_SIZE-1:0] IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATA_SIZE-1:0] OUT_DATA
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [STAT_SIZE-1:0] STALL_COUNT
`endif
);

  localparam logic [DATA_SIZE-1:0] LP_RESET_DATA = {DATA_SIZE{PIPE_RESET_DATA}};

  pipe_state_t          r_state;
  pipe_state_t          w_state_nxt;
  logic [DATA_SIZE-1:0] r_main;
  logic [DATA_SIZE-1:0] r_skid;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 w_accept;
  logic                 w_consume;
  logic                 w_main_load;
  logic                 w_main_from_skid;
  logic                 w_skid_load;

  assign w_accept  = IN_VALID & r_in_ready;
  assign w_consume = r_out_valid & OUT_READY;

  // Next-state and data-load decode; FLUSH overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (FLUSH) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = TWO;
            w_skid_load = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = ONE;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_state_nxt      = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end else begin
            w_state_nxt = TWO;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= pipe_in_ready(w_state_nxt);
      r_out_valid <= pipe_out_valid(w_state_nxt);
    end
  end

  // Payload registers; a flush clears only validity, so contents are kept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main <= LP_RESET_DATA;
      r_skid <= LP_RESET_DATA;
    end else begin
      if (w_main_load) begin
        r_main <= w_main_from_skid ? r_skid : IN_DATA;
      end
      if (w_skid_load) begin
        r_skid <= IN_DATA;
      end
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_main;

`ifdef PIPE_STALL_STATS_EN
  logic [STAT_SIZE-1:0] r_stall_count;

  // Saturating stall counter; only RST clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_count <= {STAT_SIZE{1'b0}};
    end else if (r_out_valid && !OUT_READY && (r_stall_count != {STAT_SIZE{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(STAT_SIZE-1){1'b0}}, 1'b1};
    end
  end

  assign STALL_COUNT = r_stall_count;
`endif

endmodule

// File: tb/tb_pipe_skid_register.sv
// Self-checking bench for pipe_skid_register: queue scoreboard of accepted words,
// compared against OUT_DATA every cycle; covers the stall counter when PIPE_STALL_STATS_EN is set.
module tb_pipe_skid_register;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
`ifdef PIPE_STALL_STATS_EN
  logic [SW-1:0] STALL_COUNT;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_main;
  logic [SW-1:0] exp_stall;

  pipe_skid_register #(.DATA_SIZE(DW), .STAT_SIZE(SW)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
`ifdef PIPE_STALL_STATS_EN
    , .STALL_COUNT(STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, OUT_VALID}, {31'd0, (sb_q.size() != 0)});
    chk({tag, "_in_ready"},  {31'd0, IN_READY},  {31'd0, (sb_q.size() < 2)});
    chk({tag, "_out_data"},  OUT_DATA, exp_main);
`ifdef PIPE_STALL_STATS_EN
    chk({tag, "_stall"}, {28'd0, STALL_COUNT}, {28'd0, exp_stall});
`endif
  endtask

  // One clock cycle: drive at negedge, check before posedge, update the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input string tag);
    logic acc;
    logic con;
    IN_VALID  = v;
    IN_DATA   = d;
    OUT_READY = ordy;
    FLUSH     = fl;
    #1;
    chk_outputs(tag);
    acc = v && (sb_q.size() < 2);
    con = ordy && (sb_q.size() != 0);
    if (sb_q.size() != 0 && !ordy && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (con) void'(sb_q.pop_front());
      if (acc) sb_q.push_back(d);
      if (sb_q.size() != 0) exp_main = sb_q[0];
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = 32'd0; OUT_READY = 1'b0;
    exp_main  = 32'hFFFF_FFFF;
    exp_stall = 4'd0;
    @(negedge CLK);
    #1;
    chk_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Streaming at full throughput
    step(1'b1, 32'h11, 1'b1, 1'b0, "stream0");
    step(1'b1, 32'h22, 1'b1, 1'b0, "stream1");
    step(1'b1, 32'h33, 1'b1, 1'b0, "stream2");
    step(1'b0, 32'h0,  1'b1, 1'b0, "stream3");
    step(1'b0, 32'h0,  1'b1, 1'b0, "stream4");

    // Backpressure fills the skid; extra word offered while full is ignored
    step(1'b1, 32'hA0, 1'b0, 1'b0, "bp0");
    step(1'b1, 32'hB0, 1'b0, 1'b0, "bp1");
    step(1'b1, 32'hDD, 1'b0, 1'b0, "bp_full_ign");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, "bp_hold");
    step(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain0");
    step(1'b0, 32'h0, 1'b1, 1'b0, "bp_drain1");
    step(1'b0, 32'h0, 1'b1, 1'b0, "empty_ready");

    // Simultaneous accept and consume in ONE
    step(1'b1, 32'h55, 1'b0, 1'b0, "sim0");
    step(1'b1, 32'h66, 1'b1, 1'b0, "sim1");
    step(1'b0, 32'h0,  1'b0, 1'b0, "sim2");
    step(1'b0, 32'h0,  1'b1, 1'b0, "sim3");

    // Flush from TWO with a concurrent offer
    step(1'b1, 32'h01, 1'b0, 1'b0, "fl0");
    step(1'b1, 32'h02, 1'b0, 1'b0, "fl1");
    step(1'b1, 32'hCC, 1'b1, 1'b1, "fl_flush");
    step(1'b0, 32'h0,  1'b1, 1'b0, "fl_after");
    step(1'b1, 32'h03, 1'b1, 1'b0, "fl_resume");
    step(1'b0, 32'h0,  1'b1, 1'b0, "fl_resume_out");

    // Stall saturation, unaffected by flush
    step(1'b1, 32'h77, 1'b0, 1'b0, "stall_load");
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0, "stall_hold");
    step(1'b0, 32'h0, 1'b0, 1'b1, "stall_flush");
    step(1'b0, 32'h0, 1'b0, 1'b0, "stall_post");

    // Randomised traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), "rand");
    end

    // Asynchronous reset in the middle of a cycle while full
    step(1'b1, 32'hE1, 1'b0, 1'b0, "mid0");
    step(1'b1, 32'hE2, 1'b0, 1'b0, "mid1");
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    sb_q.delete();
    exp_main  = 32'hFFFF_FFFF;
    exp_stall = 4'd0;
    chk_outputs("mid_reset");
    @(negedge CLK);
    RST = 1'b0;
    step(1'b0, 32'h0,  1'b1, 1'b0, "post_reset");
    step(1'b1, 32'h99, 1'b1, 1'b0, "post_reset_in");
    step(1'b0, 32'h0,  1'b1, 1'b0, "post_reset_out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
